branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage branch resolution unit for the pipelined RV32I core.
- Evaluates all six RV32I conditional branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Holds a direct-mapped table of 2-bit saturating counters (BHT). The table gives IF-stage taken/not-taken predictions and is trained on each resolved branch.
- Raises a registered mispredict flush with the redirect PC for the hazard unit and PC mux.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries; must be a power of 2 and at least 2.
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all state and outputs.
- pc_if  in  XLEN  IF-stage PC used for BHT lookup.
- pred_taken_if  out  1  combinational prediction: counter[idx(pc_if)][1].
- ex_valid  in  1  EX-stage instruction valid.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch funct3.
- ex_rs1, ex_rs2  in  XLEN  forwarded operands.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed branch target (ex_pc + imm).
- ex_pred_taken  in  1  prediction that travelled with the instruction from IF.
- flush  out  1  registered; mispredict detected in the previous cycle.
- redirect_pc  out  XLEN  registered; correct next PC, valid while flush=1.
- illegal_br  out  1  registered; branch seen with unsupported funct3.
- br_count, mispred_count  out  32  performance counters (see Optional Feature).

Behaviour:
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1 : 2].
- Resolve (combinational), active when res = ex_valid & ex_branch & !stall & !flush:
  - 000 BEQ: taken = rs1 == rs2.
  - 001 BNE: taken = rs1 != rs2.
  - 100 BLT: taken = signed rs1 < rs2.
  - 101 BGE: taken = signed rs1 >= rs2.
  - 110 BLTU: taken = unsigned rs1 < rs2.
  - 111 BGEU: taken = unsigned rs1 >= rs2.
  - 010, 011: taken = 0, and illegal_br asserts next cycle.
- Mispredict: taken != ex_pred_taken.
  - Next cycle: flush=1.
  - redirect_pc = taken ? ex_target : ex_pc + 4, computed mod 2^XLEN so it wraps.
  - flush, redirect_pc and illegal_br are each valid for exactly one cycle.
- Self-kill: while flush=1, the EX input is a wrong-path instruction.
  - It is ignored: no resolve, no BHT update, no counters, no new flush.
  - Back-to-back flushes are therefore impossible.
- BHT update on res:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
  - Illegal funct3: no BHT update.
- Same-cycle lookup and update of the same index: pred_taken_if returns the pre-update value (read-before-write).
- stall=1: BHT, counters and all registered outputs hold their values; a pending flush is held until the stall is released.
- Reset (asynchronous, any time including mid-flush):
  - flush=0, redirect_pc=0, illegal_br=0.
  - Every BHT entry = CTR_INIT.
  - br_count=0, mispred_count=0.
- Latency: resolve to flush/redirect is 1 cycle; table update is visible to lookup on the next cycle.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - br_count increments on every res with a legal funct3.
  - mispred_count increments on every mispredict.
  - Both wrap at 2^32 and both hold during stall.
- Undefined: no counter registers are built; br_count and mispred_count are tied to 0. The port list is unchanged.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - typedef ctr2_t (2-bit counter).
  - Constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
- Sub-module bht_2bit (params DEPTH, INIT) owns:
  - the counter array;
  - the combinational read port;
  - the saturating update port (en, idx, taken);
  - the asynchronous reset.
- The comparator and flush register stay in the top level.

Test Plan:
- BEQ, rs1=rs2=5, ex_pred_taken=0, ex_target=0x100, ex_pc=0x40 -> next cycle flush=1, redirect_pc=0x100. The cycle after: flush=0, BHT[16] moves 01->10.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken (signed -1<1), no flush. BLTU with the same operands, pred=1 -> flush, redirect_pc=ex_pc+4.
- Four consecutive taken resolves at ex_pc=0x80 -> counter 01->10->11->11 (saturates); pred_taken_if for pc_if=0x80 is 1 from the cycle after the first update.
- funct3=010 with ex_branch=1 -> illegal_br=1 for one cycle, no flush, BHT unchanged. Wrong-path branch presented while flush=1 -> ignored.
- Mispredict registered, then stall=1 for 3 cycles -> flush and redirect_pc held for all 3 cycles. Assert reset mid-stall -> flush=0 immediately (asynchronous), all BHT entries=01.
- With BRU_PERF_CNT_EN: 10 branches, 3 mispredicted -> br_count=10, mispred_count=3. Without the macro -> both read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared branch funct3 encodings, 2-bit counter type and the
//               saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
    if (taken) begin
      return (c == CTR_ST) ? CTR_ST : ctr2_t'(c + 2'd1);
    end
    return (c == CTR_SNT) ? CTR_SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bht_2bit.sv
// ============================================================================
// Module      : bht_2bit
// Description : Direct-mapped table of 2-bit saturating counters with a
//               combinational read port and one saturating update port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_2bit
  import branch_pkg::*;
#(
  parameter int    DEPTH = 64,
  parameter ctr2_t INIT  = CTR_WNT,
  localparam int   IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output ctr2_t         rd_ctr,
  input  logic          en,
  input  logic [IW-1:0] wr_idx,
  input  logic          taken
);

  ctr2_t r_ctr [DEPTH];

  // Read sees the stored value, so a same-index update lands next cycle.
  assign rd_ctr = r_ctr[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= INIT;
      end
    end else if (en) begin
      r_ctr[wr_idx] <= ctr_next(r_ctr[wr_idx], taken);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage RV32I branch resolver with 2-bit BHT prediction and
//               registered mispredict flush/redirect. Optional performance
//               counters are built when BRU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int    XLEN      = 32,
  parameter int    BHT_DEPTH = 64,
  parameter ctr2_t CTR_INIT  = CTR_WNT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IW = $clog2(BHT_DEPTH);

  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_illegal_br;
  logic            w_res;
  logic            w_legal;
  logic            w_taken;
  logic            w_mispred;
  logic [XLEN-1:0] w_redirect;
  ctr2_t           w_pred_ctr;
  logic            w_unused_bits;

  // The instruction in EX while flush is high is wrong-path and is ignored.
  assign w_res = ex_valid & ex_branch & ~stall & ~r_flush;

  always_comb begin
    w_legal = 1'b1;
    w_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  w_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  w_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: w_taken = (ex_rs1 <  ex_rs2);
      F3_BGEU: w_taken = (ex_rs1 >= ex_rs2);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_mispred  = w_res & (w_taken != ex_pred_taken);
  assign w_redirect = w_taken ? ex_target : (ex_pc + XLEN'(4));

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .INIT  (CTR_INIT)
  ) u_bht (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (pc_if[IW+1:2]),
    .rd_ctr (w_pred_ctr),
    .en     (w_res & w_legal),
    .wr_idx (ex_pc[IW+1:2]),
    .taken  (w_taken)
  );

  assign pred_taken_if = w_pred_ctr[1];
  assign w_unused_bits = ^{pc_if[XLEN-1:IW+2], pc_if[1:0], w_pred_ctr[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_illegal_br  <= 1'b0;
    end else if (!stall) begin
      r_flush      <= w_mispred;
      r_illegal_br <= w_res & ~w_legal;
      if (w_mispred) begin
        r_redirect_pc <= w_redirect;
      end
    end
  end

  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign illegal_br  = r_illegal_br;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_res & w_legal) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_mispred) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic        ex_valid;
  logic        ex_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_chk = 0;
  int n_bad = 0;

  branch_resolve_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_if         (pc_if),
    .pred_taken_if (pred_taken_if),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_funct3     (ex_funct3),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .illegal_br    (illegal_br),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    ex_valid      = 1'b1;
    ex_branch     = 1'b1;
    ex_funct3     = f3;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    pc_if = 32'h40;
    idle();
    br(F3_BEQ, 0, 0, 0, 0, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_illegal", {31'd0, illegal_br}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mis_count", mispred_count, 32'd0);
    chk("rst_pred", {31'd0, pred_taken_if}, 32'd0);

    // BEQ taken, predicted not-taken -> redirect to target
    br(F3_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0);
    tick(); idle();
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h100);
    chk("beq_bht_upd", {31'd0, pred_taken_if}, 32'd1);
    tick();
    chk("beq_flush_clr", {31'd0, flush}, 32'd0);

    // Signed vs unsigned on the same operands
    br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b1);
    tick(); idle();
    chk("blt_noflush", {31'd0, flush}, 32'd0);
    br(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b1);
    tick(); idle();
    chk("bltu_flush", {31'd0, flush}, 32'd1);
    chk("bltu_redirect", redirect_pc, 32'h204);
    tick();

    // Fall-through PC wraps past 2^32; then a wrong-path branch during flush
    br(F3_BNE, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h10, 1'b1);
    tick();
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    chk("wrap_redirect", redirect_pc, 32'h0);
    br(F3_BEQ, 32'd1, 32'd1, 32'h80, 32'h90, 1'b0);
    tick(); idle();
    chk("wp_noflush", {31'd0, flush}, 32'd0);
    pc_if = 32'h80;
    #1;
    chk("wp_bht", {31'd0, pred_taken_if}, 32'd0);

    // Four taken at 0x80: 01->10->11->11, then two not-taken: 11->10->01
    for (int i = 0; i < 4; i++) begin
      br(F3_BEQ, 32'd3, 32'd3, 32'h80, 32'h90, 1'b1);
      tick();
      chk("sat_pred", {31'd0, pred_taken_if}, 32'd1);
      chk("sat_noflush", {31'd0, flush}, 32'd0);
    end
    br(F3_BEQ, 32'd3, 32'd4, 32'h80, 32'h90, 1'b0);
    tick();
    chk("dec1_pred", {31'd0, pred_taken_if}, 32'd1);
    br(F3_BEQ, 32'd3, 32'd4, 32'h80, 32'h90, 1'b0);
    tick(); idle();
    chk("dec2_pred", {31'd0, pred_taken_if}, 32'd0);

`ifdef BRU_PERF_CNT_EN
    chk("perf_br", br_count, 32'd10);
    chk("perf_mis", mispred_count, 32'd3);
`else
    chk("perf_br", br_count, 32'd0);
    chk("perf_mis", mispred_count, 32'd0);
`endif

    // Unsupported funct3: illegal flag only, BHT untouched
    br(3'b010, 32'd1, 32'd1, 32'h80, 32'h90, 1'b0);
    tick(); idle();
    chk("ill_flag", {31'd0, illegal_br}, 32'd1);
    chk("ill_noflush", {31'd0, flush}, 32'd0);
    chk("ill_bht", {31'd0, pred_taken_if}, 32'd0);
    tick();
    chk("ill_clr", {31'd0, illegal_br}, 32'd0);

    br(F3_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h480, 1'b0);
    tick(); idle();
    chk("bgeu_flush", {31'd0, flush}, 32'd1);
    chk("bgeu_redirect", redirect_pc, 32'h480);
    tick();

    // Pending flush held across a 3-cycle stall
    br(F3_BGE, 32'hFFFF_FFFE, 32'd3, 32'h300, 32'h380, 1'b1);
    tick(); idle();
    stall = 1'b1;
    br(F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stl_flush", {31'd0, flush}, 32'd1);
      chk("stl_redirect", redirect_pc, 32'h304);
      tick();
    end
    idle();
    stall = 1'b0;
    tick();
    chk("stl_release", {31'd0, flush}, 32'd0);

    // Asynchronous reset in the middle of a stalled flush
    pc_if = 32'h40;
    br(F3_BEQ, 32'd7, 32'd7, 32'h40, 32'h500, 1'b0);
    tick(); idle();
    stall = 1'b1;
    chk("prerst_pred", {31'd0, pred_taken_if}, 32'd1);
    tick();
    chk("prerst_flush", {31'd0, flush}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_redirect", redirect_pc, 32'd0);
    chk("arst_pred40", {31'd0, pred_taken_if}, 32'd0);
    chk("arst_br_count", br_count, 32'd0);
    chk("arst_mis_count", mispred_count, 32'd0);
    pc_if = 32'h80;
    #1;
    chk("arst_pred80", {31'd0, pred_taken_if}, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
